load_store_unit: RTL

- Sits between the pipeline memory stage and the word-addressed data memory.
- Accepts byte-addressed RV32I load/store requests over a valid/ready handshake and drives the memory's word address, din, w_en and R_en.
- Sign- or zero-extends load data and performs read-modify-write sequencing for SB/SH.
- Flags misaligned, illegal-funct3 and out-of-range accesses without touching memory.

---
 rtl/load_store_unit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit between the memory stage and a word-addressed data memory.
// Loads and SW take one memory cycle; SB/SH do read-modify-write over two cycles.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_SIZE  = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_SIZE-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_SIZE-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_w_en,
  output logic                  mem_R_en,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  // Handshake: a request transfers on a posedge where req_valid & req_ready;
  // req_ready is high only in IDLE out of reset, and resp_valid is a
  // one-cycle pulse whose resp_rdata/resp_err hold until the next response.

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, ERR} state_t;

  localparam logic [ADDR_SIZE-1:0] DEPTH_W = ADDR_SIZE'(MEM_DEPTH);

  state_t                state, state_next;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_SIZE-1:0]  addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] merged_q;
  logic                  req_err;

  function automatic logic [DATA_WIDTH-1:0] extend(input logic [2:0] f3,
                                                   input logic [1:0] lane,
                                                   input logic [DATA_WIDTH-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    extend = {{(DATA_WIDTH-8){b[7]}}, b};
      3'd1:    extend = {{(DATA_WIDTH-16){h[15]}}, h};
      3'd4:    extend = {{(DATA_WIDTH-8){1'b0}}, b};
      3'd5:    extend = {{(DATA_WIDTH-16){1'b0}}, h};
      default: extend = w;
    endcase
  endfunction

  // funct3[0] distinguishes SH from SB once SW has been excluded.
  function automatic logic [DATA_WIDTH-1:0] merge(input logic [2:0] f3,
                                                  input logic [1:0] lane,
                                                  input logic [DATA_WIDTH-1:0] w,
                                                  input logic [DATA_WIDTH-1:0] wd);
    merge = w;
    if (f3[0]) merge[{lane[1], 4'b0000} +: 16] = wd[15:0];
    else       merge[{lane, 3'b000} +: 8]      = wd[7:0];
  endfunction

  always_comb begin
    req_err = 1'b0;
    if (req_we) begin
      if (req_funct3 > 3'd2) req_err = 1'b1;
    end else if (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7) begin
      req_err = 1'b1;
    end
    if (req_funct3[1:0] == 2'b01 && req_addr[0]) req_err = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if ((req_addr >> 2) >= DEPTH_W) req_err = 1'b1;
  end

  assign req_ready = (state == IDLE) && !rst;
  assign mem_addr  = addr_q >> 2;

  always_comb begin
    state_next = state;
    mem_R_en   = 1'b0;
    mem_w_en   = 1'b0;
    mem_din    = '0;
    case (state)
      IDLE:   if (req_valid) state_next = req_err ? ERR : ACCESS;
      ACCESS: begin
        if (!we_q) begin
          mem_R_en   = 1'b1;
          state_next = IDLE;
        end else if (f3_q == 3'd2) begin
          mem_w_en   = 1'b1;
          mem_din    = wdata_q;
          state_next = IDLE;
        end else begin
          mem_R_en   = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE: begin
        mem_w_en   = 1'b1;
        mem_din    = merged_q;
        state_next = IDLE;
      end
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merged_q   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_next;
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          f3_q    <= req_funct3;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          // Errors answer in the ERR cycle itself, one cycle after acceptance.
          if (req_err) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end
        end
        ACCESS: begin
          if (we_q && f3_q != 3'd2) begin
            merged_q <= merge(f3_q, addr_q[1:0], mem_dout, wdata_q);
          end else begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= we_q ? '0 : extend(f3_q, addr_q[1:0], mem_dout);
          end
        end
        WRITE: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
